hazard_ctrl_r: RTL

Pipeline hazard controller for the five-stage ARM-subset core. It compares the decode stage's registered source addresses against destinations in execute and memory. From that it generates the stall and flush controls that the decode stage consumes, plus operand-forwarding selects for execute. It also sequences multi-cycle flushes after a taken branch and keeps saturating stall/flush event counters for debug.

---
 rtl/hazard_ctrl_r.sv | 118 +++++++++++
 1 files changed

// File: rtl/hazard_ctrl_r.sv
// Pipeline hazard controller: operand forwarding selects, load-use stall,
// multi-cycle flush sequencing after taken branches, and saturating debug counters.
module hazard_ctrl_r #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             dec_valid_i,
  input  logic [3:0]       dec_r1_addr_i,
  input  logic [3:0]       dec_r2_addr_i,
  input  logic             ex_valid_i,
  input  logic [3:0]       ex_rd_addr_i,
  input  logic             ex_wb_en_i,
  input  logic             ex_is_load_i,
  input  logic             ex_br_taken_i,
  input  logic             mem_valid_i,
  input  logic [3:0]       mem_rd_addr_i,
  input  logic             mem_wb_en_i,
  output logic             stall_o,
  output logic             flush_o,
  output logic [1:0]       fwd_a_sel_o,
  output logic [1:0]       fwd_b_sel_o,
  output logic             busy_flush_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [2:0]       RELOAD  = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [2:0]       r_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_ex_hit_a;
  logic w_ex_hit_b;
  logic w_mem_hit_a;
  logic w_mem_hit_b;
  logic w_load_use;
  logic w_stall;

  // R15 is the PC: it never matches a producer, so it is never forwarded and never stalls.
  assign w_ex_hit_a  = ex_valid_i & ex_wb_en_i & (ex_rd_addr_i == dec_r1_addr_i) &
                       (dec_r1_addr_i != 4'hF);
  assign w_ex_hit_b  = ex_valid_i & ex_wb_en_i & (ex_rd_addr_i == dec_r2_addr_i) &
                       (dec_r2_addr_i != 4'hF);
  assign w_mem_hit_a = mem_valid_i & mem_wb_en_i & (mem_rd_addr_i == dec_r1_addr_i) &
                       (dec_r1_addr_i != 4'hF);
  assign w_mem_hit_b = mem_valid_i & mem_wb_en_i & (mem_rd_addr_i == dec_r2_addr_i) &
                       (dec_r2_addr_i != 4'hF);

  // A load in EX has no result yet, so it cannot feed the EX bypass.
  always_comb begin
    fwd_a_sel_o = 2'b00;
    fwd_b_sel_o = 2'b00;
    if (dec_valid_i) begin
      if (w_ex_hit_a & ~ex_is_load_i) fwd_a_sel_o = 2'b01;
      else if (w_mem_hit_a)           fwd_a_sel_o = 2'b10;
      if (w_ex_hit_b & ~ex_is_load_i) fwd_b_sel_o = 2'b01;
      else if (w_mem_hit_b)           fwd_b_sel_o = 2'b10;
    end
  end

  assign w_load_use = dec_valid_i & ex_is_load_i & (w_ex_hit_a | w_ex_hit_b);

  // A taken branch or an active flush squashes the instruction, so stalling is pointless.
  assign w_stall = w_load_use & (r_state == IDLE) & ~ex_br_taken_i & ~reset_i;

  assign stall_o      = w_stall;
  assign flush_o      = (r_state == FLUSH);
  assign busy_flush_o = (r_state == FLUSH);
  assign stall_cnt_o  = r_stall_cnt;
  assign flush_cnt_o  = r_flush_cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ex_br_taken_i) begin
            r_state <= FLUSH;
            r_cnt   <= RELOAD;
          end
        end
        FLUSH: begin
          if (ex_br_taken_i) begin
            r_cnt <= RELOAD;
          end else if (r_cnt == 3'd0) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (ex_br_taken_i && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_ONE;
    end
  end

endmodule
